vector_addsub_sequencer: RTL and testbench

VECTOR_ADDSUB_SEQUENCER -- requirements
Module: vector_addsub_sequencer

---
 rtl/vector_addsub_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_vector_addsub_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_addsub_sequencer.sv
// Purpose: sequences a vector add/sub over a shared LANE_W-bit adder slice, one beat at a time.
// Latency: rd_en of beat k at T+1+3k, write of beat k at T+3+3k, done at T+3N+1, ready at T+3N+2.
// Backpressure: cmd_ready is high only in IDLE; command inputs are ignored while busy.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   cmd_*                 - command handshake and fields (op, element width, length, registers)
//   rf_rd_*               - register-file read port (data returns the cycle after rf_rd_en)
//   au_*                  - external adder slice operands, controls, result and valid flag
//   rf_wr_*               - register-file write port with per-byte enables
//   busy, done, err       - status: not idle, completion pulse, error pulse
module vector_addsub_sequencer #(
  parameter int MAX_VLEN = 512,
  parameter int LANE_W   = 128,
  localparam int NBEAT   = MAX_VLEN / LANE_W,
  localparam int BW      = (NBEAT > 1) ? $clog2(NBEAT) : 1,
  localparam int VLW     = $clog2(MAX_VLEN / 8) + 1,
  localparam int BEW     = LANE_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_sub,
  input  logic [1:0]        cmd_sew,
  input  logic [VLW-1:0]    cmd_vl,
  input  logic [4:0]        cmd_vs1,
  input  logic [4:0]        cmd_vs2,
  input  logic [4:0]        cmd_vd,
  output logic              rf_rd_en,
  output logic [4:0]        rf_rd_addr1,
  output logic [4:0]        rf_rd_addr2,
  output logic [BW-1:0]     rf_rd_beat,
  input  logic [LANE_W-1:0] rf_rd_data1,
  input  logic [LANE_W-1:0] rf_rd_data2,
  output logic              au_ctrl,
  output logic              au_sew_16_32,
  output logic              au_sew_32,
  output logic [LANE_W-1:0] au_a,
  output logic [LANE_W-1:0] au_b,
  input  logic [LANE_W-1:0] au_sum,
  input  logic              au_done,
  output logic              rf_wr_en,
  output logic [4:0]        rf_wr_addr,
  output logic [BW-1:0]     rf_wr_beat,
  output logic [LANE_W-1:0] rf_wr_data,
  output logic [BEW-1:0]    rf_wr_be,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LB_SH = $clog2(BEW);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    EXEC   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [BW-1:0]     beat_q;
  logic [LANE_W-1:0] sum_q;
  logic              sub_q;
  logic [1:0]        sew_q;
  logic [4:0]        vs1_q, vs2_q, vd_q;
  logic [VLW-1:0]    bytes_q;   // active byte count of the whole vector
  logic [VLW-1:0]    last_q;    // index of the final beat
  logic              err_q;

  // Command decode: clamp the element count to what fits in one register,
  // then convert to bytes and to a beat count.
  logic [VLW-1:0] vlmax, vl_eff, bytes_in, last_in;
  logic           last_beat;

  always_comb begin
    vlmax = VLW'((MAX_VLEN / 8) >> cmd_sew);
    vl_eff = (cmd_vl > vlmax) ? vlmax : cmd_vl;
    case (cmd_sew)
      2'b01:   bytes_in = {vl_eff[VLW-2:0], 1'b0};
      2'b10:   bytes_in = {vl_eff[VLW-3:0], 2'b00};
      default: bytes_in = vl_eff;
    endcase
    // bytes + BEW-1 never exceeds 2*MAX bytes - 1, so VLW bits suffice.
    last_in = ((bytes_in + VLW'(BEW - 1)) >> LB_SH) - VLW'(1);
  end

  assign last_beat = (VLW'(beat_q) == last_q);

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      beat_q  <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      sew_q   <= 2'b00;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      bytes_q <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sub_q   <= cmd_sub;
            sew_q   <= cmd_sew;
            vs1_q   <= cmd_vs1;
            vs2_q   <= cmd_vs2;
            vd_q    <= cmd_vd;
            bytes_q <= bytes_in;
            last_q  <= last_in;
            beat_q  <= '0;
            err_q   <= (cmd_sew == 2'b11);
          end
        end
        EXEC: begin
          if (au_done) begin
            sum_q <= au_sum;
          end else begin
            err_q <= 1'b1;
          end
        end
        WRITE: begin
          if (!last_beat) begin
            beat_q <= beat_q + BW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          // Illegal width and empty vectors finish without touching the RF.
          if (cmd_sew == 2'b11 || vl_eff == '0) begin
            state_nx = FINISH;
          end else begin
            state_nx = READ;
          end
        end
      end
      READ:    state_nx = EXEC;
      EXEC:    state_nx = au_done ? WRITE : FINISH;
      WRITE:   state_nx = last_beat ? FINISH : READ;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs; everything idles at zero outside its own state.
  always_comb begin
    cmd_ready    = 1'b0;
    rf_rd_en     = 1'b0;
    rf_rd_addr1  = '0;
    rf_rd_addr2  = '0;
    rf_rd_beat   = '0;
    au_ctrl      = 1'b0;
    au_sew_16_32 = 1'b0;
    au_sew_32    = 1'b0;
    au_a         = '0;
    au_b         = '0;
    rf_wr_en     = 1'b0;
    rf_wr_addr   = '0;
    rf_wr_beat   = '0;
    rf_wr_data   = '0;
    rf_wr_be     = '0;
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      IDLE: cmd_ready = 1'b1;
      READ: begin
        rf_rd_en    = 1'b1;
        rf_rd_addr1 = vs1_q;
        rf_rd_addr2 = vs2_q;
        rf_rd_beat  = beat_q;
      end
      EXEC: begin
        au_a         = rf_rd_data1;
        au_b         = rf_rd_data2;
        au_ctrl      = sub_q;
        au_sew_16_32 = (sew_q == 2'b01) || (sew_q == 2'b10);
        au_sew_32    = (sew_q == 2'b10);
      end
      WRITE: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = vd_q;
        rf_wr_beat = beat_q;
        rf_wr_data = sum_q;
        // Bytes past the end of the vector in the final beat are masked.
        for (int j = 0; j < BEW; j++) begin
          rf_wr_be[j] = ((int'(beat_q) * BEW + j) < int'(bytes_q));
        end
      end
      FINISH: begin
        done = 1'b1;
        err  = err_q;
      end
      default: begin
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_vector_addsub_sequencer.sv
module tb_vector_addsub_sequencer;
  localparam int MAX_VLEN = 512;
  localparam int LANE_W   = 128;
  localparam int BW       = 2;
  localparam int VLW      = 7;
  localparam int BEW      = 16;

  typedef logic [LANE_W-1:0] word_t;

  typedef struct {
    int         off;
    int         beat;
    logic [4:0] a1;
    logic [4:0] a2;
  } rd_t;

  typedef struct {
    int             off;
    int             beat;
    logic [4:0]     addr;
    word_t          data;
    logic [BEW-1:0] be;
  } wr_t;

  typedef struct {
    int   off;
    logic err;
  } dn_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_sub = 1'b0;
  logic [1:0]        cmd_sew = 2'b00;
  logic [VLW-1:0]    cmd_vl = '0;
  logic [4:0]        cmd_vs1 = '0, cmd_vs2 = '0, cmd_vd = '0;
  logic              rf_rd_en;
  logic [4:0]        rf_rd_addr1, rf_rd_addr2;
  logic [BW-1:0]     rf_rd_beat;
  word_t             rf_rd_data1 = '0, rf_rd_data2 = '0;
  logic              au_ctrl, au_sew_16_32, au_sew_32;
  word_t             au_a, au_b, au_sum;
  logic              au_done;
  logic              rf_wr_en;
  logic [4:0]        rf_wr_addr;
  logic [BW-1:0]     rf_wr_beat;
  word_t             rf_wr_data;
  logic [BEW-1:0]    rf_wr_be;
  logic              busy, done, err;

  vector_addsub_sequencer #(.MAX_VLEN(MAX_VLEN), .LANE_W(LANE_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sub(cmd_sub), .cmd_sew(cmd_sew),
    .cmd_vl(cmd_vl), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
    .rf_rd_en(rf_rd_en), .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_beat(rf_rd_beat), .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .au_ctrl(au_ctrl), .au_sew_16_32(au_sew_16_32), .au_sew_32(au_sew_32),
    .au_a(au_a), .au_b(au_b), .au_sum(au_sum), .au_done(au_done),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_beat(rf_wr_beat),
    .rf_wr_data(rf_wr_data), .rf_wr_be(rf_wr_be),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int t_cmd = 0;
  int kill_beat = -1;
  logic done_seen = 1'b0;

  rd_t rd_q[$];
  wr_t wr_q[$];
  dn_t dn_q[$];

  logic [MAX_VLEN-1:0] mem [32];
  logic [BW-1:0] rd_beat_q = '0;

  task automatic check(input string tag, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Element-wise add/sub with no carry or borrow across element boundaries.
  function automatic word_t lane_op(input word_t a, input word_t b, input logic sub,
                                    input logic [1:0] sew);
    word_t r;
    r = '0;
    case (sew)
      2'd0: for (int i = 0; i < LANE_W/8; i++)
              r[i*8 +: 8] = sub ? a[i*8 +: 8] - b[i*8 +: 8] : a[i*8 +: 8] + b[i*8 +: 8];
      2'd1: for (int i = 0; i < LANE_W/16; i++)
              r[i*16 +: 16] = sub ? a[i*16 +: 16] - b[i*16 +: 16] : a[i*16 +: 16] + b[i*16 +: 16];
      2'd2: for (int i = 0; i < LANE_W/32; i++)
              r[i*32 +: 32] = sub ? a[i*32 +: 32] - b[i*32 +: 32] : a[i*32 +: 32] + b[i*32 +: 32];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Register-file read model: data returns one cycle after the strobe.
  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rd_data1 <= mem[rf_rd_addr1][int'(rf_rd_beat)*LANE_W +: LANE_W];
      rf_rd_data2 <= mem[rf_rd_addr2][int'(rf_rd_beat)*LANE_W +: LANE_W];
      rd_beat_q   <= rf_rd_beat;
    end
  end

  // External adder model driven purely by the DUT's control outputs.
  logic [1:0] au_sew_code;
  always_comb begin
    case ({au_sew_16_32, au_sew_32})
      2'b00:   au_sew_code = 2'd0;
      2'b10:   au_sew_code = 2'd1;
      2'b11:   au_sew_code = 2'd2;
      default: au_sew_code = 2'd3;
    endcase
    au_sum  = lane_op(au_a, au_b, au_ctrl, au_sew_code);
    au_done = !(kill_beat >= 0 && int'(rd_beat_q) == kill_beat);
  end

  // Output monitor: every strobe must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (rf_rd_en) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        rd_t e;
        e = rd_q.pop_front();
        check("rd_time", word_t'(cyc - t_cmd), word_t'(e.off));
        check("rd_beat", word_t'(rf_rd_beat), word_t'(e.beat));
        check("rd_addr1", word_t'(rf_rd_addr1), word_t'(e.a1));
        check("rd_addr2", word_t'(rf_rd_addr2), word_t'(e.a2));
      end
    end
    if (rf_wr_en) begin
      if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_time", word_t'(cyc - t_cmd), word_t'(e.off));
        check("wr_beat", word_t'(rf_wr_beat), word_t'(e.beat));
        check("wr_addr", word_t'(rf_wr_addr), word_t'(e.addr));
        check("wr_data", rf_wr_data, e.data);
        check("wr_be", word_t'(rf_wr_be), word_t'(e.be));
      end
    end
    if (done) begin
      done_seen <= 1'b1;
      if (dn_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        dn_t e;
        e = dn_q.pop_front();
        check("done_time", word_t'(cyc - t_cmd), word_t'(e.off));
        check("done_err", word_t'(err), word_t'(e.err));
      end
    end
    if (err && !done) check("err_without_done", 1, 0);
  end

  // Push expectations for one command; kb >= 0 makes the adder fail in that beat.
  task automatic expect_cmd(input logic sub, input logic [1:0] sew, input int vl,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                            input int kb);
    int vmax, vle, nbytes, n, nrd, nwr;
    dn_t dn;
    if (sew == 2'b11) begin
      dn.off = 1; dn.err = 1'b1; nrd = 0; nwr = 0;
    end else begin
      vmax   = (MAX_VLEN/8) >> sew;
      vle    = (vl < vmax) ? vl : vmax;
      nbytes = vle << sew;
      n      = (nbytes + BEW - 1) / BEW;
      if (n == 0) begin
        dn.off = 1; dn.err = 1'b0; nrd = 0; nwr = 0;
      end else if (kb >= 0 && kb < n) begin
        dn.off = 3*kb + 3; dn.err = 1'b1; nrd = kb + 1; nwr = kb;
      end else begin
        dn.off = 3*n + 1; dn.err = 1'b0; nrd = n; nwr = n;
      end
      for (int k = 0; k < nrd; k++) begin
        rd_t r;
        r.off = 1 + 3*k; r.beat = k; r.a1 = s1; r.a2 = s2;
        rd_q.push_back(r);
      end
      for (int k = 0; k < nwr; k++) begin
        wr_t w;
        w.off  = 3 + 3*k;
        w.beat = k;
        w.addr = d;
        w.data = lane_op(mem[s1][k*LANE_W +: LANE_W], mem[s2][k*LANE_W +: LANE_W], sub, sew);
        for (int j = 0; j < BEW; j++) w.be[j] = ((k*BEW + j) < nbytes);
        wr_q.push_back(w);
      end
    end
    dn_q.push_back(dn);
  endtask

  task automatic issue(input logic sub, input logic [1:0] sew, input int vl,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    @(negedge clk);
    cmd_sub = sub; cmd_sew = sew; cmd_vl = VLW'(vl);
    cmd_vs1 = s1; cmd_vs2 = s2; cmd_vd = d;
    cmd_valid = 1'b1;
    t_cmd = cyc;
    done_seen = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("busy_after_accept", word_t'(busy), 1);
    check("ready_low_when_busy", word_t'(cmd_ready), 0);
  endtask

  task automatic run_cmd(input logic sub, input logic [1:0] sew, input int vl,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input int kb);
    expect_cmd(sub, sew, vl, s1, s2, d, kb);
    kill_beat = kb;
    issue(sub, sew, vl, s1, s2, d);
    for (int i = 0; i < 100 && !done_seen; i++) begin
      @(negedge clk);
      #1;
    end
    if (!done_seen) check("done_timeout", 0, 1);
    @(negedge clk);
    #1;
    check("ready_back", word_t'(cmd_ready), 1);
    check("busy_clear", word_t'(busy), 0);
    check("rd_left", word_t'(rd_q.size()), 0);
    check("wr_left", word_t'(wr_q.size()), 0);
    check("done_left", word_t'(dn_q.size()), 0);
    rd_q.delete(); wr_q.delete(); dn_q.delete();
    kill_beat = -1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int w = 0; w < MAX_VLEN/32; w++)
        mem[r][w*32 +: 32] = $urandom;

    // Reset state.
    #12;
    check("rst_ready", word_t'(cmd_ready), 1);
    check("rst_busy", word_t'(busy), 0);
    check("rst_rd_en", word_t'(rf_rd_en), 0);
    check("rst_wr_en", word_t'(rf_wr_en), 0);
    check("rst_done", word_t'(done), 0);
    check("rst_err", word_t'(err), 0);
    check("rst_au_a", au_a, 0);
    check("rst_wr_be", word_t'(rf_wr_be), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_cmd(1'b0, 2'b10, 16, 5'd1, 5'd2, 5'd3, -1);   // 4 full beats of 32b adds
    run_cmd(1'b1, 2'b00, 5,  5'd4, 5'd5, 5'd6, -1);   // 1 beat, be=001F
    run_cmd(1'b1, 2'b01, 9,  5'd7, 5'd8, 5'd9, -1);   // 2 beats, beat1 be=0003
    run_cmd(1'b0, 2'b10, 0,  5'd1, 5'd2, 5'd3, -1);   // empty vector
    run_cmd(1'b0, 2'b11, 8,  5'd1, 5'd2, 5'd3, -1);   // illegal width
    run_cmd(1'b0, 2'b00, 64, 5'd10, 5'd11, 5'd12, -1); // full register of bytes
    // vl=100 clamps to 16 at 32b; adder fails in beat 2.
    run_cmd(1'b0, 2'b10, 100, 5'd13, 5'd14, 5'd15, 2);

    for (int i = 0; i < 6; i++) begin
      run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom_range(0, 127),
              5'($urandom_range(0, 9)), 5'($urandom_range(10, 19)),
              5'($urandom_range(20, 31)), -1);
    end

    // Reset during beat-1 EXEC: beat 0 is written, nothing after.
    begin
      rd_t r;
      wr_t w;
      r.off = 1; r.beat = 0; r.a1 = 5'd1; r.a2 = 5'd2; rd_q.push_back(r);
      r.off = 4; r.beat = 1; rd_q.push_back(r);
      w.off = 3; w.beat = 0; w.addr = 5'd3; w.be = '1;
      w.data = lane_op(mem[1][0 +: LANE_W], mem[2][0 +: LANE_W], 1'b0, 2'b10);
      wr_q.push_back(w);
    end
    issue(1'b0, 2'b10, 16, 5'd1, 5'd2, 5'd3);
    repeat (4) @(negedge clk);          // now at T+5, beat-1 EXEC
    #1;
    reset = 1'b1;
    #1;
    check("rstmid_busy", word_t'(busy), 0);
    check("rstmid_ready", word_t'(cmd_ready), 1);
    check("rstmid_wr_en", word_t'(rf_wr_en), 0);
    check("rstmid_done", word_t'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("rstmid_rd_left", word_t'(rd_q.size()), 0);
    check("rstmid_wr_left", word_t'(wr_q.size()), 0);
    check("rstmid_no_done", word_t'(done_seen), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
